// File: rtl/clock_pkg.sv
// Shared time-of-day field widths, limits and the hhhhh_mmmmmm_ssssss layout.
// Reused by the time keeper, the date stage and the display driver.
package clock_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int TIME_W = HOUR_W + MIN_W + SEC_W;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int SEC_LSB  = 0;
    localparam int MIN_LSB  = SEC_LSB + SEC_W;
    localparam int HOUR_LSB = MIN_LSB + MIN_W;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } time_t;

    function automatic logic [TIME_W-1:0] pack_time(input logic [HOUR_W-1:0] h,
                                                    input logic [MIN_W-1:0]  m,
                                                    input logic [SEC_W-1:0]  s);
        return {h, m, s};
    endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Control/status bundle of the time keeper; master drives controls, slave is the keeper.
interface time_keeper_if;

    // Level/strobe interface, no handshake: every input is sampled on each rising
    // clk edge, and every output pulse is high for exactly one cycle.
    logic                         run;
    logic                         time_ow;
    logic [clock_pkg::TIME_W-1:0] time_in;
    logic                         inc_min;
    logic                         inc_hour;
    logic [clock_pkg::TIME_W-1:0] time_out;
    logic                         sec_tick;
    logic                         day_tick;
    logic                         ow_err;

    modport master (
        output run, time_ow, time_in, inc_min, inc_hour,
        input  time_out, sec_tick, day_tick, ow_err
    );

    modport slave (
        input  run, time_ow, time_in, inc_min, inc_hour,
        output time_out, sec_tick, day_tick, ow_err
    );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with load, manual increment and cascade enable.
// carry flags the enabled wrap so the next stage advances on the same edge.
module wrap_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             carry
);

    logic [WIDTH-1:0] r_value;
    logic             w_at_max;
    logic [WIDTH-1:0] w_next;

    assign w_at_max = (r_value == WIDTH'(MAX));
    assign w_next   = w_at_max ? '0 : r_value + WIDTH'(1);

    // Manual inc never produces a carry; only the cascade enable does.
    assign carry = en && w_at_max;
    assign value = r_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_val;
        end else if (inc || en) begin
            r_value <= w_next;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// Wall-clock time of day: prescaler to a 1 s tick, cascaded sec/min/hour counters,
// synchronous validated overwrite and stopped-mode minute/hour adjustment.
module time_keeper
    import clock_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int PRESC_W  = 27
) (
    input  logic          clk,
    input  logic          rst,
    time_keeper_if.slave  bus
);

    logic [PRESC_W-1:0] r_presc;
    logic               r_sec_tick;
    logic               r_day_tick;
    logic               r_ow_err;

    logic               w_tick;
    logic               w_adj;
    logic [SEC_W-1:0]   w_in_sec;
    logic [MIN_W-1:0]   w_in_min;
    logic [HOUR_W-1:0]  w_in_hour;
    logic               w_sec_ok;
    logic               w_min_ok;
    logic               w_hour_ok;
    logic [SEC_W-1:0]   w_ld_sec;
    logic [MIN_W-1:0]   w_ld_min;
    logic [HOUR_W-1:0]  w_ld_hour;
    logic [SEC_W-1:0]   w_sec;
    logic [MIN_W-1:0]   w_min;
    logic [HOUR_W-1:0]  w_hour;
    logic               w_sec_carry;
    logic               w_min_carry;
    logic               w_hour_carry;

    // Overwrite outranks the tick, so a load edge never counts.
    assign w_tick = bus.run && !bus.time_ow && (r_presc == PRESC_W'(CLK_FREQ - 1));
    assign w_adj  = !bus.run && !bus.time_ow;

    assign w_in_sec  = bus.time_in[SEC_LSB  +: SEC_W];
    assign w_in_min  = bus.time_in[MIN_LSB  +: MIN_W];
    assign w_in_hour = bus.time_in[HOUR_LSB +: HOUR_W];

    assign w_sec_ok  = (w_in_sec  <= SEC_W'(SEC_MAX));
    assign w_min_ok  = (w_in_min  <= MIN_W'(MIN_MAX));
    assign w_hour_ok = (w_in_hour <= HOUR_W'(HOUR_MAX));

    assign w_ld_sec  = w_sec_ok  ? w_in_sec  : '0;
    assign w_ld_min  = w_min_ok  ? w_in_min  : '0;
    assign w_ld_hour = w_hour_ok ? w_in_hour : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (bus.time_ow) begin
            r_presc <= '0;
        end else if (bus.run) begin
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec_tick <= 1'b0;
            r_day_tick <= 1'b0;
            r_ow_err   <= 1'b0;
        end else begin
            r_sec_tick <= w_tick;
            r_day_tick <= w_hour_carry;
            r_ow_err   <= bus.time_ow && !(w_sec_ok && w_min_ok && w_hour_ok);
        end
    end

    wrap_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .en       (w_tick),
        .inc      (1'b0),
        .load     (bus.time_ow),
        .load_val (w_ld_sec),
        .value    (w_sec),
        .carry    (w_sec_carry)
    );

    wrap_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk      (clk),
        .rst      (rst),
        .en       (w_sec_carry),
        .inc      (w_adj && bus.inc_min),
        .load     (bus.time_ow),
        .load_val (w_ld_min),
        .value    (w_min),
        .carry    (w_min_carry)
    );

    wrap_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk      (clk),
        .rst      (rst),
        .en       (w_min_carry),
        .inc      (w_adj && bus.inc_hour),
        .load     (bus.time_ow),
        .load_val (w_ld_hour),
        .value    (w_hour),
        .carry    (w_hour_carry)
    );

    assign bus.time_out = pack_time(w_hour, w_min, w_sec);
    assign bus.sec_tick = r_sec_tick;
    assign bus.day_tick = r_day_tick;
    assign bus.ow_err   = r_ow_err;

endmodule

// File: tb/tb_time_keeper.sv
// Randomized bench for time_keeper (CLK_FREQ=4) against a seconds-of-day reference model.
module tb_time_keeper;

    localparam int CF = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   fails = 0;

    // Reference model: time of day as plain seconds since midnight plus a phase count.
    int   m_tod = 0;
    int   m_pres = 0;
    logic m_sec = 1'b0;
    logic m_day = 1'b0;
    logic m_err = 1'b0;

    time_keeper_if tk_if ();

    time_keeper #(.CLK_FREQ(CF), .PRESC_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tk_if)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] exp_time();
        int h, m, s;
        h = m_tod / 3600;
        m = (m_tod / 60) % 60;
        s = m_tod % 60;
        return {h[4:0], m[5:0], s[5:0]};
    endfunction

    function automatic logic [16:0] mk(input int h, input int m, input int s);
        return {h[4:0], m[5:0], s[5:0]};
    endfunction

    task automatic model_step(input logic r, input logic rn, input logic ow,
                              input logic [16:0] tin, input logic im, input logic ih);
        int h, m, s;
        m_sec = 1'b0;
        m_day = 1'b0;
        m_err = 1'b0;
        if (r) begin
            m_tod = 0;
            m_pres = 0;
        end else if (ow) begin
            h = int'(tin[16:12]);
            m = int'(tin[11:6]);
            s = int'(tin[5:0]);
            m_err = (h > 23) || (m > 59) || (s > 59);
            if (h > 23) h = 0;
            if (m > 59) m = 0;
            if (s > 59) s = 0;
            m_tod = h * 3600 + m * 60 + s;
            m_pres = 0;
        end else if (!rn) begin
            h = m_tod / 3600;
            m = (m_tod / 60) % 60;
            s = m_tod % 60;
            if (im) m = (m + 1) % 60;
            if (ih) h = (h + 1) % 24;
            m_tod = h * 3600 + m * 60 + s;
        end else if (m_pres == CF - 1) begin
            m_pres = 0;
            m_tod = (m_tod + 1) % 86400;
            m_sec = 1'b1;
            m_day = (m_tod == 0);
        end else begin
            m_pres = m_pres + 1;
        end
    endtask

    task automatic cycle(input logic r, input logic rn, input logic ow,
                         input logic [16:0] tin, input logic im, input logic ih);
        rst = r;
        tk_if.run = rn;
        tk_if.time_ow = ow;
        tk_if.time_in = tin;
        tk_if.inc_min = im;
        tk_if.inc_hour = ih;
        @(posedge clk);
        model_step(r, rn, ow, tin, im, ih);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        vectors++;
        if ({tk_if.time_out, tk_if.sec_tick, tk_if.day_tick, tk_if.ow_err} !== {exp_time(), m_sec, m_day, m_err}) begin
            fails++;
            $display("FAIL reset: got t=%h st=%b dt=%b err=%b, need t=%h st=%b dt=%b err=%b",
                     tk_if.time_out, tk_if.sec_tick, tk_if.day_tick, tk_if.ow_err, exp_time(), m_sec, m_day, m_err);
        end
    endtask

    task automatic test_count();
        int first = -1;
        for (int i = 1; i <= 13; i++) begin
            cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            if (tk_if.sec_tick && first < 0) first = i;
            vectors++;
            if ({tk_if.time_out, tk_if.sec_tick, tk_if.day_tick} !== {exp_time(), m_sec, m_day}) begin
                fails++;
                $display("FAIL count[%0d]: got t=%h st=%b dt=%b, need t=%h st=%b dt=%b",
                         i, tk_if.time_out, tk_if.sec_tick, tk_if.day_tick, exp_time(), m_sec, m_day);
            end
        end
        vectors++;
        if (first != CF) begin
            fails++;
            $display("FAIL first_tick: got cycle %0d, need %0d", first, CF);
        end
    endtask

    task automatic test_rollover();
        int days = 0;
        logic [16:0] prev = '0;
        cycle(1'b0, 1'b1, 1'b1, mk(23, 59, 58), 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            prev = tk_if.time_out;
            cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            if (tk_if.day_tick) days++;
            vectors++;
            if ({tk_if.time_out, tk_if.sec_tick, tk_if.day_tick} !== {exp_time(), m_sec, m_day}) begin
                fails++;
                $display("FAIL rollover[%0d]: got t=%h st=%b dt=%b, need t=%h st=%b dt=%b",
                         i, tk_if.time_out, tk_if.sec_tick, tk_if.day_tick, exp_time(), m_sec, m_day);
            end
        end
        vectors++;
        if (prev !== mk(23, 59, 59) || tk_if.time_out !== mk(0, 0, 0) || days != 1) begin
            fails++;
            $display("FAIL day_edge: got prev=%h now=%h days=%0d, need prev=%h now=0 days=1",
                     prev, tk_if.time_out, days, mk(23, 59, 59));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        vectors++;
        if (tk_if.day_tick !== 1'b0) begin
            fails++;
            $display("FAIL day_once: got day_tick=%b, need 0", tk_if.day_tick);
        end
    endtask

    task automatic test_ow_err();
        logic [16:0] tin;
        int first = -1;
        cycle(1'b0, 1'b1, 1'b1, mk(25, 61, 30), 1'b0, 1'b0);
        vectors++;
        if ({tk_if.time_out, tk_if.ow_err, tk_if.sec_tick} !== {mk(0, 0, 30), 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL ow_bad: got t=%h err=%b st=%b, need t=%h err=1 st=0",
                     tk_if.time_out, tk_if.ow_err, tk_if.sec_tick, mk(0, 0, 30));
        end
        for (int i = 1; i <= CF; i++) begin
            cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            if (tk_if.sec_tick && first < 0) first = i;
        end
        vectors++;
        if (first != CF || tk_if.ow_err !== 1'b0) begin
            fails++;
            $display("FAIL ow_presc: got tick at %0d err=%b, need tick at %0d err=0", first, tk_if.ow_err, CF);
        end
        for (int i = 0; i < 24; i++) begin
            tin = mk($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, tin, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            vectors++;
            if ({tk_if.time_out, tk_if.sec_tick, tk_if.day_tick, tk_if.ow_err} !== {exp_time(), m_sec, m_day, m_err}) begin
                fails++;
                $display("FAIL ow_rand[%0d] in=%h: got t=%h st=%b dt=%b err=%b, need t=%h st=%b dt=%b err=%b",
                         i, tin, tk_if.time_out, tk_if.sec_tick, tk_if.day_tick, tk_if.ow_err,
                         exp_time(), m_sec, m_day, m_err);
            end
        end
    endtask

    task automatic test_adjust();
        logic [16:0] want [8];
        logic [16:0] tin [8];
        logic        rn [8];
        logic        ow [8];
        logic        im [8];
        logic        ih [8];
        want = '{mk(10, 59, 40), mk(10, 0, 40), mk(23, 30, 15), mk(0, 30, 15),
                 mk(1, 31, 15), mk(1, 31, 15), mk(1, 31, 15), mk(4, 5, 6)};
        tin  = '{mk(10, 59, 40), '0, mk(23, 30, 15), '0, '0, '0, '0, mk(4, 5, 6)};
        ow   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        rn   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        im   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        ih   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, rn[i], ow[i], tin[i], im[i], ih[i]);
            vectors++;
            if ({tk_if.time_out, tk_if.day_tick} !== {exp_time(), m_day} || (i != 5 && i != 6 && tk_if.time_out !== want[i])) begin
                fails++;
                $display("FAIL adjust[%0d]: got t=%h dt=%b, need t=%h dt=%b", i, tk_if.time_out, tk_if.day_tick, exp_time(), m_day);
            end
        end
    endtask

    task automatic test_pause();
        int wait_c = -1;
        cycle(1'b0, 1'b1, 1'b1, mk(5, 6, 7), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
            vectors++;
            if ({tk_if.time_out, tk_if.sec_tick} !== {exp_time(), m_sec}) begin
                fails++;
                $display("FAIL paused[%0d]: got t=%h st=%b, need t=%h st=%b", i, tk_if.time_out, tk_if.sec_tick, exp_time(), m_sec);
            end
        end
        for (int i = 1; i <= 2 * CF && wait_c < 0; i++) begin
            cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            if (tk_if.sec_tick) wait_c = i;
        end
        vectors++;
        if (wait_c != CF - 2 || tk_if.time_out !== mk(5, 6, 8)) begin
            fails++;
            $display("FAIL resume: got tick after %0d t=%h, need %0d t=%h", wait_c, tk_if.time_out, CF - 2, mk(5, 6, 8));
        end
    endtask

    task automatic test_reset_collision();
        cycle(1'b1, 1'b1, 1'b1, mk(25, 10, 10), 1'b0, 1'b0);
        vectors++;
        if ({tk_if.time_out, tk_if.day_tick, tk_if.ow_err} !== {exp_time(), m_day, m_err}) begin
            fails++;
            $display("FAIL rst_ow: got t=%h dt=%b err=%b, need t=%h dt=%b err=%b",
                     tk_if.time_out, tk_if.day_tick, tk_if.ow_err, exp_time(), m_day, m_err);
        end
        cycle(1'b0, 1'b1, 1'b1, mk(23, 59, 59), 1'b0, 1'b0);
        for (int i = 0; i < CF - 1; i++) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        vectors++;
        if ({tk_if.time_out, tk_if.sec_tick, tk_if.day_tick, tk_if.ow_err} !== {17'd0, 3'b000}) begin
            fails++;
            $display("FAIL rst_roll: got t=%h st=%b dt=%b err=%b, need all zero",
                     tk_if.time_out, tk_if.sec_tick, tk_if.day_tick, tk_if.ow_err);
        end
    endtask

    task automatic test_random();
        logic rn = 1'b1;
        logic r, ow;
        logic [16:0] tin;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) rn = ~rn;
            r   = ($urandom_range(0, 63) == 0);
            ow  = ($urandom_range(0, 15) == 0);
            tin = ($urandom_range(0, 1) == 0) ? mk(23, 59, $urandom_range(50, 63))
                                              : mk($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            cycle(r, rn, ow, tin, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            vectors++;
            if ({tk_if.time_out, tk_if.sec_tick, tk_if.day_tick, tk_if.ow_err} !== {exp_time(), m_sec, m_day, m_err}) begin
                fails++;
                $display("FAIL random[%0d]: got t=%h st=%b dt=%b err=%b, need t=%h st=%b dt=%b err=%b",
                         i, tk_if.time_out, tk_if.sec_tick, tk_if.day_tick, tk_if.ow_err,
                         exp_time(), m_sec, m_day, m_err);
            end
        end
    endtask

    initial begin
        tk_if.run = 1'b0;
        tk_if.time_ow = 1'b0;
        tk_if.time_in = '0;
        tk_if.inc_min = 1'b0;
        tk_if.inc_hour = 1'b0;
        test_reset();
        test_count();
        test_rollover();
        test_ow_err();
        test_adjust();
        test_pause();
        test_reset_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
